// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// Optional statistics counters are built only when PIPE_SKID_REG_STATS_EN is defined.
module pipe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_SKID_REG_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q;
  logic              acc, take;

  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = main_q;
  assign in_ready  = in_ready_q;

  assign acc  = in_valid & in_ready_q;
  assign take = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (acc) begin
            state_d = S_ONE;
            main_d  = in_data;
          end
        end
        S_ONE: begin
          if (acc && take) begin
            main_d = in_data;
          end else if (acc) begin
            state_d = S_FULL;
            skid_d  = in_data;
          end else if (take) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (take) begin
            state_d = S_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // in_ready is registered from the next state so out_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != S_FULL);
    end
  end

`ifdef PIPE_SKID_REG_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 1'b1;
      if (!out_valid && bubble_cnt != CNT_MAX)
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: a queue-based model checked every cycle plus literal expectations.
module tb_pipe_skid_reg;
  localparam int DATA_W = 32;
`ifdef PIPE_SKID_REG_STATS_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_SKID_REG_STATS_EN
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  pipe_skid_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_SKID_REG_STATS_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Model: the stage is a FIFO of at most two beats; out_data shows the head, or the last head once empty.
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_held;
  int                m_stalls, m_bubbles;
  int                cnt_max;
  bit                m_acc, m_take;

  initial cnt_max = (1 << CNT_W) - 1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_held    = '0;
      m_stalls  = 0;
      m_bubbles = 0;
    end else begin
      m_acc  = in_valid && (m_q.size() < 2);
      m_take = (m_q.size() > 0) && out_ready;
      if (m_q.size() > 0 && !out_ready && m_stalls < cnt_max) m_stalls++;
      if (m_q.size() == 0 && m_bubbles < cnt_max) m_bubbles++;
      if (flush) begin
        m_q.delete();
        m_held = '0;
      end else begin
        if (m_take) void'(m_q.pop_front());
        if (m_acc) m_q.push_back(in_data);
        if (m_q.size() > 0) m_held = m_q[0];
      end
    end
  end

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("model_out_valid", {31'd0, out_valid}, {31'd0, (m_q.size() > 0)});
      chk("model_in_ready", {31'd0, in_ready}, {31'd0, (m_q.size() < 2)});
      chk("model_out_data", out_data, m_held);
`ifdef PIPE_SKID_REG_STATS_EN
      chk("model_stall_cnt", {30'd0, stall_cnt}, m_stalls);
      chk("model_bubble_cnt", {30'd0, bubble_cnt}, m_bubbles);
`endif
    end
  end

  // Drive one cycle of inputs just after an edge, then advance to just after the next edge.
  task automatic step(input logic iv, input logic [DATA_W-1:0] id, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic expect3(input string name, input logic ov, input logic [DATA_W-1:0] od, input logic ir);
    chk({name, "_out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    chk({name, "_out_data"}, out_data, od);
    chk({name, "_in_ready"}, {31'd0, in_ready}, {31'd0, ir});
  endtask

  initial begin
    #12;
    expect3("reset", 1'b0, 32'h0, 1'b1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Streaming with out_ready high
    step(1'b1, 32'h11, 1'b1, 1'b0); expect3("stream0", 1'b1, 32'h11, 1'b1);
    step(1'b1, 32'h22, 1'b1, 1'b0); expect3("stream1", 1'b1, 32'h22, 1'b1);
    step(1'b1, 32'h33, 1'b1, 1'b0); expect3("stream2", 1'b1, 32'h33, 1'b1);
    step(1'b0, 32'h99, 1'b1, 1'b0); expect3("stream_drain", 1'b0, 32'h33, 1'b1);

    // Back-pressure: two beats buffered, third held upstream
    step(1'b1, 32'hA, 1'b0, 1'b0); expect3("bp_a", 1'b1, 32'hA, 1'b1);
    step(1'b1, 32'hB, 1'b0, 1'b0); expect3("bp_full", 1'b1, 32'hA, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b0); expect3("bp_hold", 1'b1, 32'hA, 1'b0);
    step(1'b1, 32'hC, 1'b1, 1'b0); expect3("bp_out_b", 1'b1, 32'hB, 1'b1);
    step(1'b1, 32'hC, 1'b1, 1'b0); expect3("bp_out_c", 1'b1, 32'hC, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0); expect3("bp_empty", 1'b0, 32'hC, 1'b1);

    // Flush while FULL with a beat offered
    step(1'b1, 32'h1, 1'b0, 1'b0);
    step(1'b1, 32'h2, 1'b0, 1'b0); expect3("pre_flush", 1'b1, 32'h1, 1'b0);
    step(1'b1, 32'hD, 1'b0, 1'b1); expect3("flush", 1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0); expect3("post_flush", 1'b0, 32'h0, 1'b1);

    // Flush in ONE with a take and an accept: the accepted beat is discarded
    step(1'b1, 32'h7, 1'b0, 1'b0);
    step(1'b1, 32'h8, 1'b1, 1'b1); expect3("flush_take", 1'b0, 32'h0, 1'b1);

    // Asynchronous reset mid-cycle
    step(1'b1, 32'h55, 1'b0, 1'b0); expect3("pre_reset", 1'b1, 32'h55, 1'b1);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1 expect3("async_reset", 1'b0, 32'h0, 1'b1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Pseudo-random traffic checked against the model each cycle
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 31) == 0));
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    expect3("drained", 1'b0, m_held, 1'b1);

`ifdef PIPE_SKID_REG_STATS_EN
    // Saturation of the stall counter, and flush not clearing it
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 32'h42, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("stall_sat", {30'd0, stall_cnt}, 32'd3);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("stall_after_flush", {30'd0, stall_cnt}, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It generalises the fixed-width stall/flush inter-stage latch to arbitrary payload width. Back-pressure is decoupled through a registered in_ready, and throughput is one beat per cycle. It sits between any two pipeline stages (F/D, D/E, E/M, M/W) and replaces hand-wired stall/flush registers.

## Interface
- DATA_W, 32, payload width in bits (≥1)
- CNT_W, 16, statistics counter width (only used with PIPE_SKID_REG_STATS_EN)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; registers clear immediately on assertion
- flush  input  1  synchronous kill of all held entries
- in_valid  input  1  upstream has a beat
- in_ready  output  1  stage can accept; driven from a register
- in_data  input  DATA_W  upstream payload
- out_valid  output  1  main entry holds a beat
- out_ready  input  1  downstream accepts
- out_data  output  DATA_W  main entry payload
- stall_cnt  output  CNT_W  (macro only) back-pressure cycles
- bubble_cnt  output  CNT_W  (macro only) empty-output cycles

## Operation
- Storage: main entry (main_v, main_d) and skid entry (skid_v, skid_d). Derived signals:
  - out_valid = main_v; out_data = main_d; in_ready = ~skid_v
  - acc = in_valid & in_ready; take = out_valid & out_ready
- State EMPTY (no entries):
  - acc → ONE; main_d ← in_data
- State ONE (main_v only):
  - acc & take → ONE; main_d ← in_data
  - acc only → FULL; skid_d ← in_data
  - take only → EMPTY
  - neither → hold
- State FULL (main_v, skid_v):
  - in_ready = 0
  - take → ONE; main_d ← skid_d; skid_v ← 0
  - else hold
- FULL is unreachable from EMPTY in one cycle.
- Beats leave in arrival order. No beat is duplicated or dropped except by flush.
- flush priority: below reset, above everything else.
  - next state EMPTY; main_d and skid_d ← 0
  - A beat accepted in the flush cycle is discarded.
  - A beat taken downstream in the flush cycle still counts as transferred.
- out_data holds its last value when out_valid = 0. It is forced to 0 only by reset or flush.
- Upstream may drop in_valid or change in_data freely. Only acc cycles sample in_data.

## Timing
- Reset values: out_valid 0, in_ready 1, out_data 0, skid_d 0, stall_cnt 0, bubble_cnt 0.
- Latency: accept at edge N → out_valid = 1 after edge N (one cycle), in EMPTY or ONE-with-take.
- Throughput: one beat per cycle while out_ready stays high.
- in_ready falls the cycle after the second unaccepted beat is stored, so up to 2 beats are buffered with out_ready low. It rises the cycle after take from FULL.
- No combinational path from out_ready to in_ready.
- Reset assertion mid-transfer drops all entries asynchronously. Deassertion is synchronised externally by the system.

## Configuration
- PIPE_SKID_REG_STATS_EN defined:
  - stall_cnt increments each cycle with out_valid & ~out_ready.
  - bubble_cnt increments each cycle with ~out_valid.
  - Both saturate at 2^CNT_W−1.
  - Cleared by reset only; flush does not clear them.
- Not defined: stall_cnt and bubble_cnt ports and logic are absent. Datapath behaviour is identical.

## Test plan
- Streaming:
  - Stimulus: out_ready = 1; push 0x11, 0x22, 0x33 on consecutive cycles.
  - Response: out_data 0x11/0x22/0x33 one cycle later each; in_ready stays 1.
- Back-pressure:
  - Stimulus: out_ready = 0; push 0xA, 0xB, 0xC.
  - Response: 0xA in main, 0xB in skid, in_ready = 0, 0xC not accepted (held upstream).
  - Then raise out_ready: outputs 0xA, 0xB, 0xC in order; in_ready returns to 1 the cycle after 0xA leaves.
- Flush in FULL:
  - Stimulus: assert flush together with in_valid (0xD).
  - Response: next cycle out_valid 0, out_data 0, in_ready 1; 0xD never appears.
- Async reset:
  - Stimulus: assert reset low mid-cycle with main_d = 0x55.
  - Response: out_valid and out_data go to 0 before the next clock edge.
- Stats (macro on, CNT_W = 2):
  - Stimulus: hold a beat with out_ready = 0 for 5 cycles.
  - Response: stall_cnt saturates at 3; flush leaves it at 3.
